lambda_arb: RTL
===============

LAMBDA_ARB -- requirements
Module: lambda_arb

Interface
REQ-001 SHALL have parameter DW, default 16, meaning data width of a lambda word.
REQ-002 SHALL have parameter AW, default 20, meaning address width.
REQ-003 SHALL have parameter DEPTH, default 400, meaning the number of valid lambda words.
REQ-004 clk  input  1  the single clock; all state SHALL be rising-edge clocked.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 i_wreq  input  1  loader write request, held until acked.
REQ-007 i_waddr  input  AW  loader write address.
REQ-008 i_wdata  input  DW  loader write data.
REQ-009 o_wack  output  1  write grant, combinational, one cycle per transfer.
REQ-010 i_rreq  input  1  decoder read request, held until acked.
REQ-011 i_raddr  input  AW  decoder read address.
REQ-012 o_rack  output  1  read grant, combinational.
REQ-013 o_rvalid  output  1  read data valid, registered.
REQ-014 o_rdata  output  DW  read data.
REQ-015 o_load_done  output  1  one-cycle pulse when DEPTH in-range writes have completed.
REQ-016 o_err  output  1  sticky out-of-range flag.
REQ-017 i_err_clr  input  1  clears o_err.
REQ-018 o_sram_wen, o_sram_waddr, o_sram_raddr, o_sram_wdata  output  1/AW/AW/DW  drive the lambda SRAM write enable, write address, read address and write data.
REQ-019 i_sram_rdata  input  DW  SRAM read data, registered inside the SRAM with 1-cycle latency; the SRAM reads only when its write enable is low.

Function
REQ-020 At most one of o_wack, o_rack SHALL be high in any cycle.
REQ-021 Only one requester active -> that requester SHALL be granted in the same cycle.
REQ-022 Both active -> the requester not granted most recently SHALL be granted (round-robin); a last_grant register SHALL update on every grant.
REQ-023 Neither active -> no grant, o_sram_wen=0, and last_grant SHALL be held.
REQ-024 A write grant SHALL drive o_sram_wen=1, o_sram_waddr=i_waddr and o_sram_wdata=i_wdata in the same cycle.
REQ-025 A read grant SHALL drive o_sram_wen=0 and o_sram_raddr=i_raddr.
REQ-026 o_rvalid SHALL be high exactly one cycle after o_rack, with o_rdata=i_sram_rdata in that cycle.
REQ-027 A write counter SHALL count acked in-range writes from 0 to DEPTH-1.
REQ-028 On the write that completes count DEPTH-1, the counter SHALL wrap to 0 and o_load_done SHALL pulse high for one cycle, the cycle after the ack.
REQ-029 o_err SHALL clear on i_err_clr; a new error in the same cycle as i_err_clr SHALL win, so o_err=1.
REQ-030 Back-to-back reads SHALL sustain one read per cycle.
REQ-031 Alternating contention SHALL yield a strict W,R,W,R grant sequence.

Reset
REQ-032 rst_n low SHALL force o_rvalid=0, o_load_done=0, o_err=0, the write counter to 0 and last_grant to READ, so that a write wins the first contention.
REQ-033 rst_n low SHALL force o_sram_wen=0 and o_wack=o_rack=0 regardless of requests.
REQ-034 A read in flight when reset asserts SHALL NOT produce o_rvalid after reset releases.

Configuration
REQ-035 Macro LAMBDA_ARB_RANGE_CHK_EN SHALL compile in address range checking.
REQ-036 With LAMBDA_ARB_RANGE_CHK_EN defined, a granted request with address >= DEPTH SHALL be acked, SHALL NOT reach the SRAM (wen=0 for writes), and SHALL set o_err.
REQ-037 With the macro defined, an out-of-range read SHALL return o_rvalid=1 with o_rdata=0, and an out-of-range write SHALL NOT advance the write counter.
REQ-038 Without LAMBDA_ARB_RANGE_CHK_EN, addresses SHALL pass unchecked, every write SHALL count, and o_err SHALL be tied to 0.

Structure
REQ-039 Package lambda_pkg SHALL hold the DW, AW and DEPTH defaults and the grant encoding (GNT_WRITE, GNT_READ).
REQ-040 The design SHALL be flat; the round-robin selection MAY be the sub-module lambda_rr2.

Verification
REQ-041 Write-only: i_wreq held with addr 0..399, data=addr -> o_wack every cycle and o_load_done pulse one cycle after the 400th ack.
REQ-042 Read latency: after the load, a read at addr 5 -> o_rack in the same cycle, then o_rvalid with o_rdata=5 one cycle later.
REQ-043 Contention: i_wreq and i_rreq held 6 cycles from reset -> grants W,R,W,R,W,R; never both high.
REQ-044 Range check (macro defined): write at addr 400 -> o_wack=1, o_sram_wen=0, o_err=1 sticky; read at addr 401 -> o_rvalid with o_rdata=0; i_err_clr -> o_err=0.
REQ-045 Reset mid-read: assert rst_n low in the cycle after o_rack -> o_rvalid=0 and the write counter reads 0 after release.

Source files
------------

// File: rtl/lambda_pkg.sv
// Shared defaults and grant encoding for the lambda SRAM arbiter.
package lambda_pkg;

   localparam int DW_DEF    = 16;
   localparam int AW_DEF    = 20;
   localparam int DEPTH_DEF = 400;

   typedef enum logic {
      GNT_WRITE = 1'b0,
      GNT_READ  = 1'b1
   } gnt_e;

   // Width of a counter holding 0..depth-1; never narrower than one bit.
   function automatic int cnt_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/lambda_rr2.sv
// Two-way round-robin selector: loader write vs decoder read.
module lambda_rr2
   import lambda_pkg::*;
(
   input  logic wreq,
   input  logic rreq,
   input  logic last_grant,
   output logic gnt_w,
   output logic gnt_r
);

   // Under contention the write wins only if the read was served last.
   always_comb begin
      gnt_w = wreq && (!rreq || (last_grant == GNT_READ));
      gnt_r = rreq && !gnt_w;
   end

endmodule

// File: rtl/lambda_arb.sv
// Arbitrates loader writes and decoder reads onto a single-port lambda SRAM.
// Define LAMBDA_ARB_RANGE_CHK_EN to compile in address range checking (o_err).
module lambda_arb
   import lambda_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int AW    = AW_DEF,
   parameter int DEPTH = DEPTH_DEF
)
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_wreq,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   output logic          o_wack,
   input  logic          i_rreq,
   input  logic [AW-1:0] i_raddr,
   output logic          o_rack,
   output logic          o_rvalid,
   output logic [DW-1:0] o_rdata,
   output logic          o_load_done,
   output logic          o_err,
   input  logic          i_err_clr,
   output logic          o_sram_wen,
   output logic [AW-1:0] o_sram_waddr,
   output logic [AW-1:0] o_sram_raddr,
   output logic [DW-1:0] o_sram_wdata,
   input  logic [DW-1:0] i_sram_rdata
);

   localparam int CW = cnt_width(DEPTH);

   logic          wreq_en;
   logic          rreq_en;
   logic          gnt_w;
   logic          gnt_r;
   logic          w_in_range;
   logic          r_in_range;
   logic          wr_count;
   gnt_e          last_grant_reg;
   gnt_e          last_grant_next;
   logic          rvalid_reg;
   logic          rd_oor_reg;
   logic          rd_oor_next;
   logic          done_reg;
   logic          done_next;
   logic [CW-1:0] wcnt_reg;
   logic [CW-1:0] wcnt_next;

   // Requests are masked while reset is held so no grant leaks out combinationally.
   assign wreq_en = i_wreq & rst_n;
   assign rreq_en = i_rreq & rst_n;

   lambda_rr2 u_rr2 (
      .wreq       (wreq_en),
      .rreq       (rreq_en),
      .last_grant (last_grant_reg),
      .gnt_w      (gnt_w),
      .gnt_r      (gnt_r)
   );

`ifdef LAMBDA_ARB_RANGE_CHK_EN
   localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

   logic err_reg;
   logic err_next;

   assign w_in_range = ({1'b0, i_waddr} < DEPTH_LIM);
   assign r_in_range = ({1'b0, i_raddr} < DEPTH_LIM);

   // A fresh error outranks a clear in the same cycle.
   always_comb begin
      err_next = err_reg;
      if (i_err_clr)
         err_next = 1'b0;
      if ((gnt_w && !w_in_range) || (gnt_r && !r_in_range))
         err_next = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_reg <= 1'b0;
      else
         err_reg <= err_next;
   end

   assign o_err = err_reg;
`else
   logic unused_err_clr;

   assign w_in_range     = 1'b1;
   assign r_in_range     = 1'b1;
   assign o_err          = 1'b0;
   assign unused_err_clr = i_err_clr;
`endif

   assign o_wack       = gnt_w;
   assign o_rack       = gnt_r;
   assign o_sram_wen   = gnt_w & w_in_range;
   assign o_sram_waddr = i_waddr;
   assign o_sram_wdata = i_wdata;
   assign o_sram_raddr = i_raddr;

   assign wr_count    = gnt_w & w_in_range;
   assign rd_oor_next = gnt_r & ~r_in_range;

   always_comb begin
      last_grant_next = last_grant_reg;
      if (gnt_w)
         last_grant_next = GNT_WRITE;
      else if (gnt_r)
         last_grant_next = GNT_READ;
   end

   // Counter wraps on the DEPTH-th accepted write; that same write raises done.
   always_comb begin
      wcnt_next = wcnt_reg;
      done_next = 1'b0;
      if (wr_count) begin
         if (wcnt_reg == CW'(DEPTH - 1)) begin
            wcnt_next = '0;
            done_next = 1'b1;
         end else begin
            wcnt_next = wcnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_reg <= GNT_READ;
         rvalid_reg     <= 1'b0;
         rd_oor_reg     <= 1'b0;
         done_reg       <= 1'b0;
         wcnt_reg       <= '0;
      end else begin
         last_grant_reg <= last_grant_next;
         rvalid_reg     <= gnt_r;
         rd_oor_reg     <= rd_oor_next;
         done_reg       <= done_next;
         wcnt_reg       <= wcnt_next;
      end
   end

   assign o_rvalid    = rvalid_reg;
   assign o_rdata     = rd_oor_reg ? '0 : i_sram_rdata;
   assign o_load_done = done_reg;

endmodule
